// File: rtl/temporizador_300ms.sv
// Button front-end: raw-pin synchronizer plus the lockout timer feeding the debouncer FSM.
// Build option: define SIM_FAST_TICK_EN to make every COUNT cycle a millisecond tick (simulation only).
module temporizador_300ms #(
  parameter int unsigned CLK_HZ      = 100000000,
  parameter int unsigned T_MS        = 300,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       boton_raw,
  input  logic                       actCuenta,
  output logic                       boton0,
  output logic                       t300ms,
  output logic                       ocupado,
  output logic [$clog2(T_MS+1)-1:0]  ms_count
);

`ifdef SIM_FAST_TICK_EN
  localparam int unsigned PRE = 1;
`else
  localparam int unsigned PRE = CLK_HZ / 1000;
`endif
  localparam int unsigned PW = (PRE > 1) ? $clog2(PRE) : 1;
  localparam int unsigned MW = $clog2(T_MS + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(PRE - 1);
  localparam logic [MW-1:0] MS_LAST  = MW'(T_MS - 1);
  localparam logic [MW-1:0] MS_MAX   = MW'(T_MS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2,
    REARM = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   pre, pre_n;
  logic [MW-1:0]   ms_n;
  logic            pulse_n;
  logic            busy_n;
  logic            tick;
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], boton_raw};
    end
  end

  assign boton0 = sync_q[SYNC_STAGES-1];

  assign tick = (pre == PRE_LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      pre      <= '0;
      ms_count <= '0;
      t300ms   <= 1'b0;
      ocupado  <= 1'b0;
    end else begin
      state    <= state_n;
      pre      <= pre_n;
      ms_count <= ms_n;
      t300ms   <= pulse_n;
      ocupado  <= busy_n;
    end
  end

  // Outputs are computed for the next state so that they register alongside it.
  always_comb begin
    state_n = state;
    pre_n   = '0;
    ms_n    = '0;
    pulse_n = 1'b0;
    busy_n  = 1'b0;
    case (state)
      IDLE: begin
        if (actCuenta) begin
          state_n = COUNT;
          busy_n  = 1'b1;
        end
      end
      COUNT: begin
        if (!actCuenta) begin
          state_n = IDLE;
        end else begin
          busy_n = 1'b1;
          ms_n   = ms_count;
          pre_n  = tick ? '0 : pre + PW'(1);
          if (tick) begin
            if (ms_count == MS_LAST) begin
              state_n = DONE;
              pulse_n = 1'b1;
              ms_n    = MS_MAX;
              pre_n   = '0;
            end else if (ms_count < MS_MAX) begin
              ms_n = ms_count + MW'(1);
            end
          end
        end
      end
      DONE: begin
        state_n = REARM;
      end
      REARM: begin
        if (!actCuenta) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_temporizador_300ms.sv
// Self-checking bench for temporizador_300ms: directed scenarios then random
// actCuenta/boton_raw activity, all compared against an elapsed-time reference model.
module tb_temporizador_300ms;

  localparam int unsigned CLK_HZ      = 10000;
  localparam int unsigned T_MS        = 3;
  localparam int unsigned SYNC_STAGES = 2;
`ifdef SIM_FAST_TICK_EN
  localparam int unsigned PRE = 1;
`else
  localparam int unsigned PRE = CLK_HZ / 1000;
`endif
  localparam int unsigned LOCK = T_MS * PRE;
  localparam int unsigned MW   = $clog2(T_MS + 1);

  logic          Clk       = 1'b0;
  logic          Reset_n   = 1'b0;
  logic          boton_raw = 1'b1;
  logic          actCuenta = 1'b1;
  logic          boton0;
  logic          t300ms;
  logic          ocupado;
  logic [MW-1:0] ms_count;

  int errors = 0;
  int checks = 0;

  // Reference model: elapsed cycles of the current lockout (-1 when not counting)
  int                     elapsed = -1;
  bit                     m_done  = 1'b0;
  bit                     m_rearm = 1'b0;
  logic [SYNC_STAGES-1:0] hist    = '0;

  int pulse_at;
  int pulses;
  int mid;

  temporizador_300ms #(
    .CLK_HZ     (CLK_HZ),
    .T_MS       (T_MS),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .boton_raw(boton_raw),
    .actCuenta(actCuenta),
    .boton0   (boton0),
    .t300ms   (t300ms),
    .ocupado  (ocupado),
    .ms_count (ms_count)
  );

  always #5 Clk = ~Clk;

  task automatic model_reset();
    elapsed = -1;
    m_done  = 1'b0;
    m_rearm = 1'b0;
    hist    = '0;
  endtask

  task automatic model_edge();
    if (!Reset_n) begin
      model_reset();
    end else begin
      hist = {hist[SYNC_STAGES-2:0], boton_raw};
      if (m_done) begin
        m_done  = 1'b0;
        m_rearm = 1'b1;
      end else if (m_rearm) begin
        if (!actCuenta) m_rearm = 1'b0;
      end else if (elapsed >= 0) begin
        if (!actCuenta) begin
          elapsed = -1;
        end else begin
          elapsed++;
          if (elapsed == int'(LOCK)) begin
            m_done  = 1'b1;
            elapsed = -1;
          end
        end
      end else if (actCuenta) begin
        elapsed = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int exp_ms;
    exp_ms = m_done ? int'(T_MS) : (elapsed >= 0 ? elapsed / int'(PRE) : 0);
    check("boton0",   32'(boton0),   32'(hist[SYNC_STAGES-1]));
    check("t300ms",   32'(t300ms),   32'(m_done));
    check("ocupado",  32'(ocupado),  32'(m_done || (elapsed >= 0)));
    check("ms_count", 32'(ms_count), 32'(exp_ms));
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_cycles(input int n);
    actCuenta = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // 1: reset held with inputs high, then synchronizer latency
    for (int i = 0; i < 3; i++) cycle();
    Reset_n = 1'b1;
    cycle();
    check("sync_edge1", 32'(boton0), 32'd0);
    cycle();
    check("sync_edge2", 32'(boton0), 32'd1);
    idle_cycles(4);

    // 2: full lockout with actCuenta held high
    actCuenta = 1'b1;
    pulse_at  = -1;
    pulses    = 0;
    for (int n = 1; n <= int'(3 * LOCK) + 10; n++) begin
      cycle();
      if (t300ms === 1'b1) begin
        pulses++;
        if (pulse_at < 0) begin
          pulse_at = n;
          check("ms_at_pulse", 32'(ms_count), 32'(T_MS));
        end
      end
      if (pulse_at > 0 && n == pulse_at + 1) check("ocupado_after", 32'(ocupado), 32'd0);
    end
    check("pulse_latency", 32'(pulse_at), 32'(LOCK + 1));
    check("single_pulse", 32'(pulses), 32'd1);
    idle_cycles(3);

    // 3: abort mid-count, then full restart
    actCuenta = 1'b1;
    mid = (LOCK > 16) ? 16 : 1;
    for (int n = 0; n < mid; n++) cycle();
    actCuenta = 1'b0;
    cycle();
    check("abort_ocupado", 32'(ocupado), 32'd0);
    check("abort_ms", 32'(ms_count), 32'd0);
    pulses = 0;
    for (int n = 0; n < int'(LOCK) + 5; n++) begin
      cycle();
      if (t300ms === 1'b1) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);
    actCuenta = 1'b1;
    pulse_at  = -1;
    for (int n = 1; n <= int'(LOCK) + 10; n++) begin
      cycle();
      if (t300ms === 1'b1 && pulse_at < 0) pulse_at = n;
    end
    check("restart_latency", 32'(pulse_at), 32'(LOCK + 1));
    idle_cycles(3);

    // 4: actCuenta falls on the final tick edge
    actCuenta = 1'b1;
    for (int n = 0; n < int'(LOCK); n++) cycle();
    actCuenta = 1'b0;
    cycle();
    check("race_t300ms", 32'(t300ms), 32'd0);
    check("race_ocupado", 32'(ocupado), 32'd0);
    check("race_ms", 32'(ms_count), 32'd0);
    idle_cycles(3);

    // 5: asynchronous reset in the middle of a count
    actCuenta = 1'b1;
    mid = (LOCK > 23) ? 23 : 2;
    for (int n = 0; n < mid; n++) cycle();
    #3;
    Reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check("arst_ocupado", 32'(ocupado), 32'd0);
    check("arst_ms", 32'(ms_count), 32'd0);
    actCuenta = 1'b0;
    #2;
    Reset_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < int'(LOCK) + 5; n++) begin
      cycle();
      if (t300ms === 1'b1) pulses++;
    end
    check("arst_no_pulse", 32'(pulses), 32'd0);

    // Random activity against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) actCuenta = ~actCuenta;
      if ($urandom_range(0, 3) == 0) boton_raw = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
